// File: rtl/apb_exe_pkg.sv
// rtl/apb_exe_pkg.sv - register map, status bits and enums shared by the apb_exe_slave slice
package apb_exe_pkg;

    localparam int ADDR_ARG_A  = 0;
    localparam int ADDR_ARG_B  = 1;
    localparam int ADDR_OP     = 2;
    localparam int ADDR_CTRL   = 3;
    localparam int ADDR_RESULT = 4;
    localparam int ADDR_STATUS = 5;

    localparam int ST_BUSY  = 0;
    localparam int ST_DONE  = 1;
    localparam int ST_ERROR = 2;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OP_SET = 2'd0,
        OP_CLR = 2'd1,
        OP_TGL = 2'd2,
        OP_TST = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2
    } state_e;

endpackage

// File: rtl/apb_exe_slave_if.sv
// rtl/apb_exe_slave_if.sv - APB bus bundle between master and the execution-unit front-end
interface apb_exe_slave_if #(
    parameter int M  = 8,
    parameter int AW = 3
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [M-1:0]  pwdata;
    logic [M-1:0]  prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_exe_lat_cnt.sv
// rtl/apb_exe_lat_cnt.sv - fixed-latency countdown; capture strobes on the cycle the count hits zero
module apb_exe_lat_cnt
    import apb_exe_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic load,
    output logic busy,
    output logic capture
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (load) begin
            cnt  <= CNT_W'(LAT);
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign capture = busy && (cnt == '0);

endmodule

// File: rtl/apb_exe_slave.sv
// rtl/apb_exe_slave.sv - APB front-end for execution unit 3; APB_EXE_SLAVE_AUTOSTART_EN adds start-on-ARG_B-write
module apb_exe_slave
    import apb_exe_pkg::*;
#(
    parameter int M   = 8,
    parameter int AW  = 3,
    parameter int LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    apb_exe_slave_if.slave    bus,
    output logic [M-1:0]      o_argA,
    output logic [M-1:0]      o_argB,
    output logic [1:0]        o_op,
    output logic              o_start,
    input  logic [M-1:0]      i_y,
    input  logic              i_error
);

    state_e         state, state_n;
    logic [M-1:0]   arg_a, arg_b, result_q, rd_val;
    op_e            op_q;
    logic           done_q, error_q, start_q;
    logic           busy, capture;
    logic           acc_ok, access_err, start_cond, wr_ok, rd_result_ok;
    logic           sel_arg_a, sel_arg_b, sel_op, sel_ctrl, sel_result, sel_status, unmapped;

    assign sel_arg_a  = bus.paddr == AW'(ADDR_ARG_A);
    assign sel_arg_b  = bus.paddr == AW'(ADDR_ARG_B);
    assign sel_op     = bus.paddr == AW'(ADDR_OP);
    assign sel_ctrl   = bus.paddr == AW'(ADDR_CTRL);
    assign sel_result = bus.paddr == AW'(ADDR_RESULT);
    assign sel_status = bus.paddr == AW'(ADDR_STATUS);
    assign unmapped   = bus.paddr > AW'(ADDR_STATUS);

    // Rejected accesses complete with pslverr and leave every register untouched.
    assign access_err = unmapped
                     || (bus.pwrite && (sel_result || sel_status))
                     || (!bus.pwrite && sel_ctrl)
                     || (bus.pwrite && busy && (sel_arg_a || sel_arg_b || sel_op || sel_ctrl));

    always_comb begin
        rd_val = '0;
        if (sel_arg_a) begin
            rd_val = arg_a;
        end else if (sel_arg_b) begin
            rd_val = arg_b;
        end else if (sel_op) begin
            rd_val[1:0] = op_q;
        end else if (sel_result) begin
            rd_val = result_q;
        end else if (sel_status) begin
            rd_val[ST_BUSY]  = busy;
            rd_val[ST_DONE]  = done_q;
            rd_val[ST_ERROR] = error_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        acc_ok      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    state_n = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!bus.psel) begin
                    state_n = S_IDLE;
                end else if (!bus.pwrite && sel_result && busy) begin
                    state_n = S_WAIT;
                end else begin
                    bus.pready  = 1'b1;
                    bus.pslverr = access_err;
                    acc_ok      = !access_err;
                    state_n     = S_IDLE;
                end
            end
            S_WAIT: begin
                // busy drops the cycle after capture, so the read returns the fresh result
                if (!bus.psel) begin
                    state_n = S_IDLE;
                end else if (!busy) begin
                    bus.pready = 1'b1;
                    acc_ok     = 1'b1;
                    state_n    = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.prdata   = (bus.pready && !bus.pwrite) ? rd_val : '0;
    assign wr_ok        = acc_ok && bus.pwrite;
    assign rd_result_ok = acc_ok && !bus.pwrite && sel_result;

`ifdef APB_EXE_SLAVE_AUTOSTART_EN
    assign start_cond = wr_ok && ((sel_ctrl && bus.pwdata[0]) || sel_arg_b);
`else
    assign start_cond = wr_ok && sel_ctrl && bus.pwdata[0];
`endif

    apb_exe_lat_cnt #(.LAT(LAT)) u_lat_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load    (start_cond),
        .busy    (busy),
        .capture (capture)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            arg_a    <= '0;
            arg_b    <= '0;
            op_q     <= OP_SET;
            result_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            start_q <= start_cond;
            if (wr_ok && sel_arg_a) arg_a <= bus.pwdata;
            if (wr_ok && sel_arg_b) arg_b <= bus.pwdata;
            if (wr_ok && sel_op)    op_q  <= op_e'(bus.pwdata[1:0]);
            if (start_cond) begin
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end
            if (capture) begin
                result_q <= i_y;
                error_q  <= i_error;
                done_q   <= 1'b1;
            end
            if (rd_result_ok) done_q <= 1'b0;
        end
    end

    assign o_argA  = arg_a;
    assign o_argB  = arg_b;
    assign o_op    = op_q;
    assign o_start = start_q;

endmodule

// File: tb/tb_apb_exe_slave.sv
// tb/tb_apb_exe_slave.sv - directed table-driven bench for apb_exe_slave with an XOR execution-unit stub
module tb_apb_exe_slave;

    localparam int LAT = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] arg_a, arg_b, y;
    logic [1:0] op;
    logic       start, exe_err;

    int checks = 0;
    int errors = 0;
    int start_cycles = 0;

    apb_exe_slave_if #(.M(8), .AW(3)) bus ();

    apb_exe_slave #(.M(8), .AW(3), .LAT(LAT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_argA  (arg_a),
        .o_argB  (arg_b),
        .o_op    (op),
        .o_start (start),
        .i_y     (y),
        .i_error (exe_err)
    );

    assign y       = arg_a ^ arg_b;
    assign exe_err = (arg_b == 8'h00);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (start) start_cycles++;

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_err;
        int         idle;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                                input logic [7:0] exp_rd, input logic exp_err, input int idle);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.idle = idle;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered and left just after a rising edge; a following call starts its setup phase back-to-back.
    task automatic apb_xfer(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                            output logic [7:0] rd, output logic err, output int waits);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wdata;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus.pready && waits < 64) begin
            waits++;
            @(negedge clk);
        end
        check("xfer_timeout", 32'(waits >= 64), 0);
        rd  = bus.prdata;
        err = bus.pslverr;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic xfer_chk(input string name, input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                            input logic [7:0] exp_rd, input logic exp_err, input int exp_waits);
        logic [7:0] rd;
        logic       err;
        int         waits;
        apb_xfer(wr, addr, wdata, rd, err, waits);
        check({name, "_rdata"}, 32'(rd), 32'(exp_rd));
        check({name, "_pslverr"}, 32'(err), 32'(exp_err));
        check({name, "_waits"}, 32'(waits), 32'(exp_waits));
    endtask

    initial begin
        int   snap;
        int   exp_starts;
        logic autostart;
`ifdef APB_EXE_SLAVE_AUTOSTART_EN
        autostart = 1'b1;
`else
        autostart = 1'b0;
`endif
        rst_n = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
        #3;
        check("rst_prdata", 32'(bus.prdata), 0);
        check("rst_pready", 32'(bus.pready), 0);
        check("rst_pslverr", 32'(bus.pslverr), 0);
        check("rst_start", 32'(start), 0);
        check("rst_args", {8'h0, arg_a, arg_b, 6'h0, op}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // ARG_B goes first with a long gap so the autostart build stays in step with the default one.
        vecs.push_back(mk(1, 3'd1, 8'd11, 8'h00, 0, 0));
        vecs.push_back(mk(1, 3'd0, 8'd7,  8'h00, 0, 8));
        vecs.push_back(mk(0, 3'd0, 8'h00, 8'h07, 0, 0));
        vecs.push_back(mk(0, 3'd1, 8'h00, 8'h0B, 0, 0));
        vecs.push_back(mk(1, 3'd2, 8'hFF, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'd2, 8'h00, 8'h03, 0, 0));
        vecs.push_back(mk(1, 3'd3, 8'h01, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'd5, 8'h00, 8'h02, 0, LAT + 2));
        vecs.push_back(mk(0, 3'd4, 8'h00, 8'h0C, 0, 0));
        vecs.push_back(mk(0, 3'd5, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, 3'd1, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, 3'd3, 8'h01, 8'h00, 0, 8));
        vecs.push_back(mk(0, 3'd5, 8'h00, 8'h06, 0, 8));
        vecs.push_back(mk(0, 3'd4, 8'h00, 8'h07, 0, 0));
        vecs.push_back(mk(0, 3'd5, 8'h00, 8'h04, 0, 0));
        vecs.push_back(mk(1, 3'd3, 8'h01, 8'h00, 0, 0));
        vecs.push_back(mk(1, 3'd0, 8'h55, 8'h00, 1, 0));
        vecs.push_back(mk(1, 3'd6, 8'hAA, 8'h00, 1, 0));
        vecs.push_back(mk(0, 3'd3, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mk(1, 3'd4, 8'h12, 8'h00, 1, 0));
        vecs.push_back(mk(1, 3'd5, 8'h34, 8'h00, 1, 0));
        vecs.push_back(mk(0, 3'd7, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mk(0, 3'd0, 8'h00, 8'h07, 0, 8));
        vecs.push_back(mk(1, 3'd3, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'd5, 8'h00, 8'h06, 0, 0));
        vecs.push_back(mk(0, 3'd4, 8'h00, 8'h07, 0, 0));
        vecs.push_back(mk(0, 3'd5, 8'h00, 8'h04, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            idle(vecs[i].idle);
            xfer_chk($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                     vecs[i].exp_rd, vecs[i].exp_err, 0);
        end
        idle(2);
        exp_starts = autostart ? 5 : 3;
        check("table_start_cycles", 32'(start_cycles), 32'(exp_starts));

        // RESULT read issued straight after a start stalls for LAT cycles.
        xfer_chk("wa_argb", 1, 3'd1, 8'h0F, 8'h00, 0, 0);
        idle(8);
        xfer_chk("wa_arga", 1, 3'd0, 8'h3C, 8'h00, 0, 0);
        xfer_chk("wa_ctrl", 1, 3'd3, 8'h01, 8'h00, 0, 0);
        xfer_chk("wa_result", 0, 3'd4, 8'h00, 8'h33, 0, LAT);
        xfer_chk("wa_status", 0, 3'd5, 8'h00, 8'h00, 0, 0);

        // o_start timing and STATUS sampled in the capture cycle.
        xfer_chk("cap_ctrl", 1, 3'd3, 8'h01, 8'h00, 0, 0);
        check("cap_start_hi", 32'(start), 1);
        check("cap_operands", {8'h0, arg_a, arg_b, 6'h0, op}, 32'h003C0F03);
        idle(1);
        check("cap_start_lo", 32'(start), 0);
        xfer_chk("cap_st_busy", 0, 3'd5, 8'h00, 8'h01, 0, 0);
        xfer_chk("cap_st_capcyc", 0, 3'd5, 8'h00, 8'h01, 0, 0);
        xfer_chk("cap_st_done", 0, 3'd5, 8'h00, 8'h02, 0, 0);
        xfer_chk("cap_result", 0, 3'd4, 8'h00, 8'h33, 0, 0);

        // psel dropped while stalled: FSM abandons the read, operation still completes.
        xfer_chk("pv_ctrl", 1, 3'd3, 8'h01, 8'h00, 0, 0);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 3'd4;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(negedge clk);
        check("pv_stall0", 32'(bus.pready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("pv_stall1", 32'(bus.pready), 0);
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        idle(6);
        xfer_chk("pv_status", 0, 3'd5, 8'h00, 8'h02, 0, 0);
        xfer_chk("pv_result", 0, 3'd4, 8'h00, 8'h33, 0, 0);

        // Asynchronous reset while busy.
        xfer_chk("rs_ctrl", 1, 3'd3, 8'h01, 8'h00, 0, 0);
        check("rs_start_before", 32'(start), 1);
        snap = start_cycles;
        rst_n = 1'b0;
        #1;
        check("rs_start", 32'(start), 0);
        check("rs_args", {8'h0, arg_a, arg_b, 6'h0, op}, 0);
        check("rs_bus", {bus.prdata, 6'h0, bus.pready, bus.pslverr}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(10);
        check("rs_no_start", 32'(start_cycles), 32'(snap));
        xfer_chk("rs_status", 0, 3'd5, 8'h00, 8'h00, 0, 0);
        xfer_chk("rs_result", 0, 3'd4, 8'h00, 8'h00, 0, 0);

        // ARG_B write launches only in the autostart build.
        snap = start_cycles;
        xfer_chk("as_arga", 1, 3'd0, 8'd3, 8'h00, 0, 0);
        xfer_chk("as_argb", 1, 3'd1, 8'd5, 8'h00, 0, 0);
        idle(2);
        check("as_starts", 32'(start_cycles - snap), autostart ? 32'd1 : 32'd0);
        idle(8);
        xfer_chk("as_result", 0, 3'd4, 8'h00, autostart ? 8'h06 : 8'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
